// File: rtl/yarvi_hostio.sv
// Host byte-stream bridge: buffered RX/TX FIFOs behind four memory-mapped
// 32-bit registers, with status, sticky TX overflow, interrupt and loopback.
`timescale 1ns/1ps
module yarvi_hostio #(
   parameter int RX_DEPTH_LOG2 = 4,
   parameter int TX_DEPTH_LOG2 = 4
) (
   input  logic        clock,
   input  logic        reset,
   output logic        rx_ready,
   input  logic        rx_valid,
   input  logic [7:0]  rx_data,
   input  logic        tx_ready,
   output logic        tx_valid,
   output logic [7:0]  tx_data,
   input  logic        bus_req,
   input  logic        bus_we,
   input  logic [3:0]  bus_addr,
   input  logic [31:0] bus_wdata,
   output logic        bus_rvalid,
   output logic [31:0] bus_rdata,
   output logic        irq
);

   localparam int RX_DEPTH = 1 << RX_DEPTH_LOG2;
   localparam int TX_DEPTH = 1 << TX_DEPTH_LOG2;

   typedef logic [RX_DEPTH_LOG2-1:0] rx_ptr_t;
   typedef logic [RX_DEPTH_LOG2:0]   rx_cnt_t;
   typedef logic [TX_DEPTH_LOG2-1:0] tx_ptr_t;
   typedef logic [TX_DEPTH_LOG2:0]   tx_cnt_t;

   localparam logic [1:0] REG_DATA    = 2'd0;
   localparam logic [1:0] REG_STATUS  = 2'd1;
   localparam logic [1:0] REG_CONTROL = 2'd2;
   localparam logic [1:0] REG_SCRATCH = 2'd3;

   logic [7:0]  r_rx_mem [RX_DEPTH];
   rx_ptr_t     r_rx_wptr, r_rx_rptr;
   rx_cnt_t     r_rx_count;
   logic [7:0]  r_tx_mem [TX_DEPTH];
   tx_ptr_t     r_tx_wptr, r_tx_rptr;
   tx_cnt_t     r_tx_count;
   logic [2:0]  r_ctrl;
   logic [31:0] r_scratch;
   logic        r_tx_ovf;
   logic        r_rvalid;
   logic [31:0] r_rdata;

   logic        w_rx_full, w_rx_empty, w_tx_full, w_tx_empty, w_loop;
   logic        w_rd, w_wr;
   logic [1:0]  w_sel;
   logic        w_rx_push, w_rx_pop, w_tx_push, w_tx_pop, w_tx_drop, w_lb_move;
   logic        w_ovf_clr;
   logic [7:0]  w_rx_head, w_tx_head, w_rx_wbyte;
   logic [31:0] w_rd_mux;
   logic        w_unused;

   assign w_rx_full  = (r_rx_count == rx_cnt_t'(RX_DEPTH));
   assign w_rx_empty = (r_rx_count == '0);
   assign w_tx_full  = (r_tx_count == tx_cnt_t'(TX_DEPTH));
   assign w_tx_empty = (r_tx_count == '0);
   assign w_loop     = r_ctrl[2];
   assign w_rx_head  = r_rx_mem[r_rx_rptr];
   assign w_tx_head  = r_tx_mem[r_tx_rptr];

   assign w_rd  = bus_req && !bus_we;
   assign w_wr  = bus_req && bus_we;
   assign w_sel = bus_addr[3:2];

   // All decisions use start-of-cycle counts, so a drain never makes room
   // for a same-cycle write and a pop never opens rx_ready combinationally.
   assign rx_ready   = !w_rx_full && !w_loop;
   assign tx_valid   = !w_tx_empty && !w_loop;
   assign tx_data    = tx_valid ? w_tx_head : 8'h00;
   assign w_lb_move  = w_loop && !w_tx_empty && !w_rx_full;
   assign w_rx_push  = (rx_valid && rx_ready) || w_lb_move;
   assign w_rx_wbyte = w_loop ? w_tx_head : rx_data;
   assign w_rx_pop   = w_rd && (w_sel == REG_DATA) && !w_rx_empty;
   assign w_tx_push  = w_wr && (w_sel == REG_DATA) && !w_tx_full;
   assign w_tx_drop  = w_wr && (w_sel == REG_DATA) && w_tx_full;
   assign w_tx_pop   = (tx_valid && tx_ready) || w_lb_move;
   assign w_ovf_clr  = w_wr && (w_sel == REG_STATUS) && bus_wdata[18];

   assign irq = (r_ctrl[0] && !w_rx_empty) || (r_ctrl[1] && w_tx_empty);

   always_comb begin
      w_rd_mux = 32'h0;
      case (w_sel)
         REG_DATA:    w_rd_mux = {!w_rx_empty, 23'h0, w_rx_empty ? 8'h00 : w_rx_head};
         REG_STATUS:  w_rd_mux = {13'h0, r_tx_ovf, w_tx_full, !w_rx_empty,
                                  8'(r_tx_count), 8'(r_rx_count)};
         REG_CONTROL: w_rd_mux = {29'h0, r_ctrl};
         default:     w_rd_mux = r_scratch;
      endcase
   end

   always_ff @(posedge clock) begin
      if (w_rx_push) r_rx_mem[r_rx_wptr] <= w_rx_wbyte;
      if (w_tx_push) r_tx_mem[r_tx_wptr] <= bus_wdata[7:0];
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_rx_wptr  <= '0;
         r_rx_rptr  <= '0;
         r_rx_count <= '0;
         r_tx_wptr  <= '0;
         r_tx_rptr  <= '0;
         r_tx_count <= '0;
      end else begin
         if (w_rx_push) r_rx_wptr <= r_rx_wptr + rx_ptr_t'(1);
         if (w_rx_pop)  r_rx_rptr <= r_rx_rptr + rx_ptr_t'(1);
         case ({w_rx_push, w_rx_pop})
            2'b10:   r_rx_count <= r_rx_count + rx_cnt_t'(1);
            2'b01:   r_rx_count <= r_rx_count - rx_cnt_t'(1);
            default: r_rx_count <= r_rx_count;
         endcase
         if (w_tx_push) r_tx_wptr <= r_tx_wptr + tx_ptr_t'(1);
         if (w_tx_pop)  r_tx_rptr <= r_tx_rptr + tx_ptr_t'(1);
         case ({w_tx_push, w_tx_pop})
            2'b10:   r_tx_count <= r_tx_count + tx_cnt_t'(1);
            2'b01:   r_tx_count <= r_tx_count - tx_cnt_t'(1);
            default: r_tx_count <= r_tx_count;
         endcase
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ctrl    <= 3'b000;
         r_scratch <= 32'h0;
         r_tx_ovf  <= 1'b0;
         r_rvalid  <= 1'b0;
         r_rdata   <= 32'h0;
      end else begin
         if (w_wr && (w_sel == REG_CONTROL)) r_ctrl <= bus_wdata[2:0];
         if (w_wr && (w_sel == REG_SCRATCH)) r_scratch <= bus_wdata;
         // A new overflow wins over a clear in the same cycle.
         if (w_tx_drop)      r_tx_ovf <= 1'b1;
         else if (w_ovf_clr) r_tx_ovf <= 1'b0;
         r_rvalid <= w_rd;
         if (w_rd) r_rdata <= w_rd_mux;
      end
   end

   assign bus_rvalid = r_rvalid;
   assign bus_rdata  = r_rdata;

   assign w_unused = &{1'b0, bus_addr[1:0]};

endmodule

// File: tb/tb_yarvi_hostio.sv
// Directed self-checking bench for yarvi_hostio (both FIFOs 4 deep).
`timescale 1ns/1ps
module tb_yarvi_hostio;

   logic        clock = 1'b0;
   logic        reset;
   logic        rx_ready, rx_valid;
   logic [7:0]  rx_data;
   logic        tx_ready, tx_valid;
   logic [7:0]  tx_data;
   logic        bus_req, bus_we, bus_rvalid, irq;
   logic [3:0]  bus_addr;
   logic [31:0] bus_wdata, bus_rdata;
   int          total = 0;
   int          bad = 0;

   yarvi_hostio #(.RX_DEPTH_LOG2(2), .TX_DEPTH_LOG2(2)) dut (
      .clock(clock), .reset(reset),
      .rx_ready(rx_ready), .rx_valid(rx_valid), .rx_data(rx_data),
      .tx_ready(tx_ready), .tx_valid(tx_valid), .tx_data(tx_data),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_wdata(bus_wdata), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
      .irq(irq)
   );

   always #5 clock = ~clock;

   // Driver tasks: entered and left 1 time unit after a rising edge.
   task automatic bus_write(input logic [3:0] a, input logic [31:0] d);
      bus_req = 1'b1; bus_we = 1'b1; bus_addr = a; bus_wdata = d;
      @(posedge clock); #1;
      bus_req = 1'b0; bus_we = 1'b0;
   endtask

   task automatic bus_read(input logic [3:0] a, output logic [31:0] d, output logic v);
      bus_req = 1'b1; bus_we = 1'b0; bus_addr = a;
      @(posedge clock); #1;
      bus_req = 1'b0;
      d = bus_rdata; v = bus_rvalid;
   endtask

   task automatic host_send(input logic [7:0] b);
      int n = 0;
      rx_valid = 1'b1; rx_data = b;
      while (!rx_ready && n < 50) begin
         @(posedge clock); #1; n++;
      end
      total++;
      if (!rx_ready) begin
         bad++;
         $display("FAIL host_send_timeout byte=%h rx_ready=%b want=1", b, rx_ready);
      end else begin
         @(posedge clock); #1;
      end
      rx_valid = 1'b0;
   endtask

   task automatic do_reset();
      reset = 1'b1; #2;
      @(posedge clock); #1;
      reset = 1'b0;
   endtask

   task automatic test_reset();
      logic [31:0] d; logic v;
      reset = 1'b1; #2;
      total++;
      if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
          bus_rvalid !== 1'b0 || bus_rdata !== 32'h0 || irq !== 1'b0) begin
         bad++;
         $display("FAIL reset_outputs got rr=%b tv=%b td=%h rv=%b rd=%h irq=%b want 1 0 00 0 0 0",
                  rx_ready, tx_valid, tx_data, bus_rvalid, bus_rdata, irq);
      end
      @(posedge clock); #1; reset = 1'b0;
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0 || v !== 1'b1) begin
         bad++; $display("FAIL reset_status got=%h v=%b want=00000000 v=1", d, v);
      end
   endtask

   task automatic test_rx_basic();
      logic [31:0] d; logic v;
      logic [31:0] exp_d [3] = '{32'h8000_0041, 32'h8000_0042, 32'h0};
      host_send(8'h41); host_send(8'h42);
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0001_0002 || v !== 1'b1) begin
         bad++; $display("FAIL rx_status got=%h v=%b want=00010002 v=1", d, v);
      end
      for (int i = 0; i < 3; i++) begin
         bus_read(4'h0, d, v);
         total++;
         if (d !== exp_d[i] || v !== 1'b1) begin
            bad++; $display("FAIL rx_data%0d got=%h want=%h", i, d, exp_d[i]);
         end
      end
   endtask

   task automatic test_tx_overflow();
      logic [31:0] d; logic v;
      tx_ready = 1'b0;
      for (int i = 0; i < 5; i++) bus_write(4'h0, 32'h10 + 32'(i));
      total++;
      if (tx_valid !== 1'b1 || tx_data !== 8'h10) begin
         bad++; $display("FAIL tx_head got v=%b d=%h want v=1 d=10", tx_valid, tx_data);
      end
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0006_0400) begin
         bad++; $display("FAIL tx_full_status got=%h want=00060400", d);
      end
      tx_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h10 + 8'(i)) begin
            bad++; $display("FAIL tx_drain%0d got v=%b d=%h want v=1 d=%h",
                            i, tx_valid, tx_data, 8'h10 + 8'(i));
         end
         @(posedge clock); #1;
      end
      tx_ready = 1'b0;
      total++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00) begin
         bad++; $display("FAIL tx_empty got v=%b d=%h want v=0 d=00", tx_valid, tx_data);
      end
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0004_0000) begin
         bad++; $display("FAIL ovf_sticky got=%h want=00040000", d);
      end
      bus_write(4'h4, 32'h0004_0000);
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0) begin
         bad++; $display("FAIL ovf_clear got=%h want=00000000", d);
      end
   endtask

   task automatic test_full_drain_same_cycle();
      logic [31:0] d; logic v;
      for (int i = 0; i < 4; i++) bus_write(4'h0, 32'h20 + 32'(i));
      tx_ready = 1'b1;
      bus_write(4'h0, 32'h99);
      tx_ready = 1'b0;
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0004_0300) begin
         bad++; $display("FAIL full_write_drain got=%h want=00040300", d);
      end
      tx_ready = 1'b1;
      for (int i = 1; i < 4; i++) begin
         total++;
         if (tx_valid !== 1'b1 || tx_data !== 8'h20 + 8'(i)) begin
            bad++; $display("FAIL drain_after_drop%0d got v=%b d=%h want v=1 d=%h",
                            i, tx_valid, tx_data, 8'h20 + 8'(i));
         end
         @(posedge clock); #1;
      end
      tx_ready = 1'b0;
      bus_write(4'h4, 32'h0004_0000);
   endtask

   task automatic test_rx_backpressure();
      logic [31:0] d; logic v;
      for (int i = 1; i <= 4; i++) host_send(8'(i));
      rx_valid = 1'b1; rx_data = 8'h05;
      total++;
      if (rx_ready !== 1'b0) begin
         bad++; $display("FAIL rx_full_ready got=%b want=0", rx_ready);
      end
      bus_read(4'h0, d, v);
      total++;
      if (d !== 32'h8000_0001 || rx_ready !== 1'b1) begin
         bad++; $display("FAIL rx_pop_reopen got d=%h rr=%b want d=80000001 rr=1", d, rx_ready);
      end
      @(posedge clock); #1;
      rx_valid = 1'b0;
      total++;
      if (rx_ready !== 1'b0) begin
         bad++; $display("FAIL rx_refull got=%b want=0", rx_ready);
      end
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0001_0004) begin
         bad++; $display("FAIL rx_bp_status got=%h want=00010004", d);
      end
      for (int i = 2; i <= 6; i++) begin
         bus_read(4'h0, d, v);
         total++;
         if (d !== ((i == 6) ? 32'h0 : 32'h8000_0000 + 32'(i))) begin
            bad++; $display("FAIL rx_bp_data%0d got=%h want=%h", i, d,
                            (i == 6) ? 32'h0 : 32'h8000_0000 + 32'(i));
         end
      end
   endtask

   task automatic test_loopback();
      logic [31:0] d; logic v;
      bus_write(4'h8, 32'h4);
      bus_write(4'h0, 32'h55);
      total++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
         bad++; $display("FAIL loop_quiet1 got tv=%b rr=%b want 0 0", tx_valid, rx_ready);
      end
      bus_write(4'h0, 32'hAA);
      total++;
      if (tx_valid !== 1'b0 || rx_ready !== 1'b0) begin
         bad++; $display("FAIL loop_quiet2 got tv=%b rr=%b want 0 0", tx_valid, rx_ready);
      end
      bus_read(4'h0, d, v);
      total++;
      if (d !== 32'h8000_0055) begin
         bad++; $display("FAIL loop_data0 got=%h want=80000055", d);
      end
      bus_read(4'h0, d, v);
      total++;
      if (d !== 32'h8000_00AA) begin
         bad++; $display("FAIL loop_data1 got=%h want=800000aa", d);
      end
      bus_read(4'h8, d, v);
      total++;
      if (d !== 32'h4) begin
         bad++; $display("FAIL control_rd got=%h want=00000004", d);
      end
      bus_write(4'h8, 32'h0);
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0) begin
         bad++; $display("FAIL loop_status got=%h want=00000000", d);
      end
   endtask

   task automatic test_irq();
      logic [31:0] d; logic v;
      do_reset();
      bus_write(4'h8, 32'h3);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_txempty got=%b want=1", irq); end
      bus_write(4'h0, 32'h77);
      total++;
      if (irq !== 1'b0) begin bad++; $display("FAIL irq_txbusy got=%b want=0", irq); end
      host_send(8'h33);
      total++;
      if (irq !== 1'b1) begin bad++; $display("FAIL irq_rx got=%b want=1", irq); end
      bus_write(4'h8, 32'h1);
      bus_read(4'h0, d, v);
      total++;
      if (irq !== 1'b0 || d !== 32'h8000_0033) begin
         bad++; $display("FAIL irq_rx_pop got irq=%b d=%h want irq=0 d=80000033", irq, d);
      end
   endtask

   task automatic test_scratch();
      logic [31:0] d; logic v;
      bus_write(4'hC, 32'hDEAD_BEEF);
      bus_read(4'hF, d, v);
      total++;
      if (d !== 32'hDEAD_BEEF || v !== 1'b1) begin
         bad++; $display("FAIL scratch got=%h v=%b want=deadbeef v=1", d, v);
      end
      @(posedge clock); #1;
      total++;
      if (bus_rvalid !== 1'b0 || bus_rdata !== 32'hDEAD_BEEF) begin
         bad++; $display("FAIL rdata_hold got v=%b d=%h want v=0 d=deadbeef", bus_rvalid, bus_rdata);
      end
      bus_write(4'h8, 32'hFFFF_FFF8);
      bus_read(4'h9, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL control_mask got=%h want=00000000", d); end
   endtask

   task automatic test_reset_midflight();
      logic [31:0] d; logic v;
      do_reset();
      host_send(8'h01); host_send(8'h02);
      bus_write(4'h0, 32'hA1); bus_write(4'h0, 32'hA2);
      bus_write(4'hC, 32'h1234_5678);
      bus_write(4'h8, 32'h1);
      bus_read(4'hC, d, v);
      total++;
      if (irq !== 1'b1 || tx_valid !== 1'b1 || bus_rdata !== 32'h1234_5678) begin
         bad++; $display("FAIL pre_reset got irq=%b tv=%b rd=%h want 1 1 12345678", irq, tx_valid, bus_rdata);
      end
      #3; reset = 1'b1; #1;
      total++;
      if (rx_ready !== 1'b1 || tx_valid !== 1'b0 || tx_data !== 8'h00 ||
          bus_rvalid !== 1'b0 || bus_rdata !== 32'h0 || irq !== 1'b0) begin
         bad++;
         $display("FAIL async_reset got rr=%b tv=%b td=%h rv=%b rd=%h irq=%b want 1 0 00 0 0 0",
                  rx_ready, tx_valid, tx_data, bus_rvalid, bus_rdata, irq);
      end
      @(posedge clock); #1; reset = 1'b0;
      bus_read(4'h4, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL post_reset_status got=%h want=00000000", d); end
      bus_read(4'hC, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL post_reset_scratch got=%h want=00000000", d); end
      bus_read(4'h8, d, v);
      total++;
      if (d !== 32'h0) begin bad++; $display("FAIL post_reset_control got=%h want=00000000", d); end
   endtask

   initial begin
      rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b0;
      bus_req = 1'b0; bus_we = 1'b0; bus_addr = 4'h0; bus_wdata = 32'h0;
      test_reset();
      test_rx_basic();
      test_tx_overflow();
      test_full_drain_same_cycle();
      test_rx_backpressure();
      test_loopback();
      test_irq();
      test_scratch();
      test_reset_midflight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/yarvi_hostio.md
# yarvi_hostio

Parametrised host byte-stream bridge for the yarvi SoC. It replaces the tied-off `rx_ready` and the debug-driven `tx_valid`/`tx_data` with buffered RX and TX FIFOs. The core reaches the FIFOs through four 32-bit memory-mapped registers. It adds status, a sticky overflow flag, interrupt generation and an internal loopback mode; it sits between the host stream ports and the core's I/O bus.

## Interface
- `RX_DEPTH_LOG2`, default 4: RX FIFO depth is 2^N entries; legal range 1..7.
- `TX_DEPTH_LOG2`, default 4: TX FIFO depth is 2^N entries; legal range 1..7.
- `clock`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high; clears all state.
- `rx_ready`  out  1  the block accepts a host byte this cycle.
- `rx_valid`  in  1  host byte present.
- `rx_data`  in  8  host byte.
- `tx_ready`  in  1  host accepts a byte.
- `tx_valid`  out  1  a byte is offered to the host.
- `tx_data`  out  8  byte to host.
- `bus_req`  in  1  register access this cycle; always accepted, no stall.
- `bus_we`  in  1  1 = write, 0 = read.
- `bus_addr`  in  4  byte address; bits [3:2] select the register, bits [1:0] are ignored.
- `bus_wdata`  in  32  write data.
- `bus_rvalid`  out  1  read data valid; asserted exactly one cycle after a read request.
- `bus_rdata`  out  32  read data.
- `irq`  out  1  level interrupt.

## Operation
- Registers, selected by `bus_addr[3:2]`:
  - 0 DATA.
    - Read: returns {rx_avail, 23'b0, byte}. When the RX FIFO is non-empty, rx_avail=1, the head byte is returned and the entry is popped. When empty, the read returns 0 and nothing is popped.
    - Write: pushes `bus_wdata[7:0]` into the TX FIFO. If the TX FIFO is full, the byte is dropped and `tx_ovf` is set.
  - 1 STATUS.
    - Read layout: [7:0] rx_count, [15:8] tx_count, [16] rx_nonempty, [17] tx_full, [18] tx_ovf, [31:19] 0.
    - Write: writing 1 to bit 18 clears `tx_ovf`. All other bits are ignored.
  - 2 CONTROL, read/write, bits [2:0]; all other bits read as 0.
    - bit 0 rxie: interrupt while the RX FIFO is non-empty.
    - bit 1 txie: interrupt while the TX FIFO is empty.
    - bit 2 loop: loopback mode.
  - 3 SCRATCH: 32-bit read/write, no side effects.
- RX push: occurs when `rx_valid && rx_ready`.
  - `rx_ready = !rx_full && !loop`. It is derived from registered state and is independent of same-cycle pops.
- TX drain:
  - `tx_valid = !tx_empty && !loop`.
  - `tx_data` is the head entry when `tx_valid` is high, else 8'h00.
  - An entry is popped when `tx_valid && tx_ready`.
- Loopback (loop=1):
  - The host ports are quiesced: `rx_ready=0`, `tx_valid=0`, and `tx_ready` is ignored.
  - Each cycle with TX non-empty and RX not full moves one byte from the TX head to the RX tail.
- `irq = (rxie && rx_nonempty) || (txie && tx_empty)`, computed from registered state.
- FIFOs are circular buffers.
  - Each has pointers of DEPTH_LOG2 bits that wrap modulo depth, plus a count of DEPTH_LOG2+1 bits.
  - full means count == depth; empty means count == 0.
  - Counts are zero-extended into the 8-bit STATUS fields.
- Simultaneous events:
  - RX push and core pop in the same cycle: both take effect and the count is unchanged.
  - TX core write and host drain in the same cycle: both take effect. Fullness is judged on the start-of-cycle count, so a write to a full FIFO is dropped even when a drain occurs in the same cycle.
  - A clear of `tx_ovf` and a new overflow in the same cycle: the flag ends set.
  - Toggling loop takes effect on the next cycle. FIFO contents are preserved.

## Timing
- Reset values (asynchronous, immediate): FIFOs empty, pointers 0, CONTROL=0, SCRATCH=0, tx_ovf=0.
- Output values while reset is held: `rx_ready=1`, `tx_valid=0`, `tx_data=0`, `bus_rvalid=0`, `bus_rdata=0`, `irq=0`.
- Reset asserted mid-transfer discards all buffered bytes. No handshake completes in the reset cycle.
- Read latency is 1 cycle.
  - `bus_rdata` and `bus_rvalid` are registered.
  - `bus_rdata` holds its last value when `bus_rvalid=0`.
- Side effects of the request cycle (pop, push, flag clear, register write) are visible in state and status from the next cycle.
- A byte pushed by the host at edge N can be returned by a DATA read requested in cycle N+1.
- A DATA write at edge N makes `tx_valid` rise in cycle N+1.
- Loopback transfer takes 1 cycle per byte, so throughput is 1 byte per cycle.

## Test plan
- Reset, then send host bytes 0x41, 0x42 -> STATUS reads 0x0001_0002 (rx_count=2, rx_nonempty=1).
  - Then two DATA reads -> 0x8000_0041, then 0x8000_0042.
  - A third DATA read -> 0x0000_0000.
- TX_DEPTH_LOG2=2, `tx_ready=0`, write five bytes 0x10..0x14 -> STATUS tx_count=4, tx_full=1, tx_ovf=1.
  - Raise `tx_ready` -> host receives 0x10..0x13 on consecutive cycles.
  - Write STATUS with 0x0004_0000 -> tx_ovf reads 0.
- Hold `rx_valid=1` with RX full; pop once -> `rx_ready` rises only in the cycle after the pop. Exactly one new byte enters; no byte is lost or duplicated.
- CONTROL=0x4, write 0x55 and 0xAA to DATA -> `tx_valid` stays 0 and `rx_ready` stays 0. DATA reads return 0x8000_0055, then 0x8000_00AA.
- CONTROL=0x3 after reset -> `irq`=1 because TX is empty.
  - Write one byte with `tx_ready=0` -> `irq`=0.
  - A host RX byte arrives -> `irq`=1.
- Assert `reset` asynchronously with both FIFOs half full -> all outputs take their reset values immediately. After release, STATUS reads 0x0000_0000 and SCRATCH reads 0.
